// File: rtl/display_scroll_ctrl.sv
// Scrolling 4-character window over a small message RAM, feeding a 4-digit seven-segment mux.
// Host loads the message while idle or paused; start/stop sequence the scroll.
module display_scroll_ctrl #(
    parameter int          ADDR_W     = 4,
    parameter int unsigned SCROLL_DIV = 25000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [3:0]        wr_data,
    output logic              wr_ready,
    input  logic              start,
    input  logic              stop,
    input  logic              dir,
    output logic [3:0]        dig3,
    output logic [3:0]        dig2,
    output logic [3:0]        dig1,
    output logic [3:0]        dig0,
    output logic              busy,
    output logic              step_pulse
);

    localparam int          MSG_LEN  = 1 << ADDR_W;
    localparam logic [31:0] DIV_LAST = 32'(SCROLL_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [31:0]       div_cnt;
    logic [3:0]        msg [MSG_LEN];

    logic [ADDR_W-1:0] idx1;
    logic [ADDR_W-1:0] idx2;
    logic [ADDR_W-1:0] idx3;

    assign wr_ready = (state != RUN);

    // Window indices wrap naturally because they are ADDR_W bits wide.
    assign idx1 = ptr + ADDR_W'(1);
    assign idx2 = ptr + ADDR_W'(2);
    assign idx3 = ptr + ADDR_W'(3);

    // Sequencer: stop has priority over start everywhere; pause freezes ptr and div_cnt.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            ptr        <= '0;
            div_cnt    <= '0;
            busy       <= 1'b0;
            step_pulse <= 1'b0;
        end else begin
            step_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (!stop && start) begin
                        state   <= RUN;
                        busy    <= 1'b1;
                        ptr     <= '0;
                        div_cnt <= '0;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state <= PAUSE;
                        busy  <= 1'b0;
                    end else if (div_cnt == DIV_LAST) begin
                        div_cnt    <= '0;
                        ptr        <= dir ? (ptr - ADDR_W'(1)) : (ptr + ADDR_W'(1));
                        step_pulse <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt + 32'd1;
                    end
                end
                PAUSE: begin
                    if (stop) begin
                        state   <= IDLE;
                        ptr     <= '0;
                        div_cnt <= '0;
                    end else if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    ptr     <= '0;
                    div_cnt <= '0;
                end
            endcase
        end
    end

    // Message store; host writes are dropped silently while scrolling.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MSG_LEN; i++) begin
                msg[i] <= '0;
            end
        end else if (wr_en && wr_ready) begin
            msg[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dig3 <= '0;
            dig2 <= '0;
            dig1 <= '0;
            dig0 <= '0;
        end else begin
            dig3 <= msg[ptr];
            dig2 <= msg[idx1];
            dig1 <= msg[idx2];
            dig0 <= msg[idx3];
        end
    end

endmodule

// File: tb/tb_display_scroll_ctrl.sv
// Scoreboard bench for display_scroll_ctrl: stimulus queues expected outputs per cycle,
// independent monitors compare window/status and step pulses on the falling edge.
module tb_display_scroll_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [3:0] wr_data;
    logic       wr_ready;
    logic       start;
    logic       stop;
    logic       dir;
    logic [3:0] dig3, dig2, dig1, dig0;
    logic       busy;
    logic       step_pulse;

    typedef struct {
        int          cyc;
        string       name;
        logic [15:0] digs;
        logic        busy;
        logic        wr_ready;
        logic        step;
    } exp_t;

    exp_t exp_q[$];
    int   step_q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   t;

    display_scroll_ctrl #(.ADDR_W(4), .SCROLL_DIV(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .start      (start),
        .stop       (stop),
        .dir        (dir),
        .dig3       (dig3),
        .dig2       (dig2),
        .dig1       (dig1),
        .dig0       (dig0),
        .busy       (busy),
        .step_pulse (step_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_cycle(input int c);
        while (cyc < c) tick();
    endtask

    task automatic apply_stimulus(input logic s_start, input logic s_stop, input logic s_dir,
                                  input logic s_wr, input logic [3:0] s_addr,
                                  input logic [3:0] s_data);
        start   = s_start;
        stop    = s_stop;
        dir     = s_dir;
        wr_en   = s_wr;
        wr_addr = s_addr;
        wr_data = s_data;
    endtask

    task automatic expect_at(input int c, input string nm, input logic [15:0] d,
                             input logic b, input logic w, input logic s);
        exp_t e;
        e.cyc = c; e.name = nm; e.digs = d; e.busy = b; e.wr_ready = w; e.step = s;
        exp_q.push_back(e);
    endtask

    task automatic check_output(input exp_t e);
        logic [18:0] act;
        logic [18:0] req;
        act = {dig3, dig2, dig1, dig0, busy, wr_ready, step_pulse};
        req = {e.digs, e.busy, e.wr_ready, e.step};
        n_checks++;
        if (e.cyc != cyc)
            $display("[TB] FAIL %s: checked at cycle %0d, required cycle %0d", e.name, cyc, e.cyc);
        else if (act === req)
            n_pass++;
        else
            $display("[TB] FAIL %s @%0d: dig=%h busy=%b wr_ready=%b step=%b, required dig=%h busy=%b wr_ready=%b step=%b",
                     e.name, cyc, act[18:3], act[2], act[1], act[0],
                     e.digs, e.busy, e.wr_ready, e.step);
    endtask

    // Window/status monitor: compares every expectation due this cycle.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            mon_e = exp_q.pop_front();
            check_output(mon_e);
        end
    end

    // Step monitor: every pulse must match the next scheduled step cycle.
    always @(negedge clk) begin
        while (step_q.size() > 0 && step_q[0] < cyc) begin
            n_checks++;
            $display("[TB] FAIL missed_step: no pulse at cycle %0d, required one", step_q.pop_front());
        end
        if (step_pulse === 1'b1) begin
            n_checks++;
            if (step_q.size() == 0)
                $display("[TB] FAIL unexpected_step: pulse at cycle %0d, required none", cyc);
            else if (step_q[0] == cyc) begin
                void'(step_q.pop_front());
                n_pass++;
            end else
                $display("[TB] FAIL step_time: pulse at cycle %0d, required at %0d", cyc, step_q[0]);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst = 1'b0;
        apply_stimulus(0, 0, 0, 0, 4'h0, 4'h0);
        tick(); tick();
        expect_at(cyc, "reset_state", 16'h0000, 0, 1, 0);
        tick();
        rst = 1'b1;

        // Load msg[i] = i while idle
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(0, 0, 0, 1, 4'(i), 4'(i));
            tick();
        end

        // Fresh start, left scroll, run through window wrap, then back to idle
        apply_stimulus(1, 0, 0, 0, 4'h0, 4'h0);
        t = cyc + 1;
        expect_at(cyc,    "idle_loaded",  16'h0123, 0, 1, 0);
        expect_at(t,      "start_busy",   16'h0123, 1, 0, 0);
        expect_at(t + 4,  "first_step",   16'h0123, 1, 0, 1);
        expect_at(t + 5,  "after_step",   16'h1234, 1, 0, 0);
        expect_at(t + 52, "step_ptr13",   16'hCDEF, 1, 0, 1);
        expect_at(t + 53, "window_ptr13", 16'hDEF0, 1, 0, 0);
        expect_at(t + 57, "window_ptr14", 16'hEF01, 1, 0, 0);
        expect_at(t + 58, "stop_pause",   16'hEF01, 0, 1, 0);
        expect_at(t + 59, "stop_idle",    16'hEF01, 0, 1, 0);
        expect_at(t + 60, "idle_ptr0",    16'h0123, 0, 1, 0);
        for (int k = 1; k <= 14; k++) step_q.push_back(t + 4 * k);
        goto_cycle(t);
        apply_stimulus(0, 0, 0, 0, 4'h0, 4'h0);
        goto_cycle(t + 57);
        apply_stimulus(0, 1, 0, 0, 4'h0, 4'h0);
        goto_cycle(t + 59);
        apply_stimulus(0, 0, 0, 0, 4'h0, 4'h0);

        // Right scroll from ptr 0 wraps to ptr 15
        goto_cycle(cyc + 3);
        apply_stimulus(1, 0, 1, 0, 4'h0, 4'h0);
        t = cyc + 1;
        expect_at(t,     "dir1_start", 16'h0123, 1, 0, 0);
        expect_at(t + 4, "dir1_step",  16'h0123, 1, 0, 1);
        expect_at(t + 5, "dir1_wrap",  16'hF012, 1, 0, 0);
        step_q.push_back(t + 4);
        goto_cycle(t);
        apply_stimulus(0, 0, 1, 0, 4'h0, 4'h0);
        goto_cycle(t + 5);
        apply_stimulus(0, 1, 0, 0, 4'h0, 4'h0);
        goto_cycle(t + 7);
        apply_stimulus(0, 0, 0, 0, 4'h0, 4'h0);

        // Write ignored while running, accepted while paused
        goto_cycle(cyc + 3);
        apply_stimulus(1, 0, 0, 0, 4'h0, 4'h0);
        t = cyc + 1;
        expect_at(t,     "run_wr_blocked", 16'h0123, 1, 0, 0);
        expect_at(t + 2, "run_wr_dropped", 16'h0123, 0, 1, 0);
        expect_at(t + 4, "pause_wr_edge",  16'h0123, 0, 1, 0);
        expect_at(t + 5, "pause_wr_shown", 16'h0923, 0, 1, 0);
        goto_cycle(t);
        apply_stimulus(0, 0, 0, 1, 4'h1, 4'h9);
        goto_cycle(t + 1);
        apply_stimulus(0, 1, 0, 0, 4'h0, 4'h0);
        goto_cycle(t + 2);
        apply_stimulus(0, 0, 0, 0, 4'h0, 4'h0);
        goto_cycle(t + 3);
        apply_stimulus(0, 0, 0, 1, 4'h1, 4'h9);
        goto_cycle(t + 4);
        apply_stimulus(0, 0, 0, 0, 4'h0, 4'h0);
        goto_cycle(t + 5);
        apply_stimulus(0, 1, 0, 0, 4'h0, 4'h0);
        goto_cycle(t + 6);
        apply_stimulus(0, 0, 0, 0, 4'h0, 4'h0);

        // Pause at div_cnt=2, resume, start+stop collision, stop back to idle
        goto_cycle(cyc + 3);
        apply_stimulus(1, 0, 0, 0, 4'h0, 4'h0);
        t = cyc + 1;
        expect_at(t + 3,  "pause_div2",    16'h0923, 0, 1, 0);
        expect_at(t + 24, "resume",        16'h0923, 1, 0, 0);
        expect_at(t + 26, "resume_step",   16'h0923, 1, 0, 1);
        expect_at(t + 27, "resume_window", 16'h9234, 1, 0, 0);
        expect_at(t + 28, "both_to_pause", 16'h9234, 0, 1, 0);
        expect_at(t + 29, "pause_to_idle", 16'h9234, 0, 1, 0);
        expect_at(t + 30, "idle_rewound",  16'h0923, 0, 1, 0);
        step_q.push_back(t + 26);
        goto_cycle(t);
        apply_stimulus(0, 0, 0, 0, 4'h0, 4'h0);
        goto_cycle(t + 2);
        apply_stimulus(0, 1, 0, 0, 4'h0, 4'h0);
        goto_cycle(t + 3);
        apply_stimulus(0, 0, 0, 0, 4'h0, 4'h0);
        goto_cycle(t + 23);
        apply_stimulus(1, 0, 0, 0, 4'h0, 4'h0);
        goto_cycle(t + 24);
        apply_stimulus(0, 0, 0, 0, 4'h0, 4'h0);
        goto_cycle(t + 27);
        apply_stimulus(1, 1, 0, 0, 4'h0, 4'h0);
        goto_cycle(t + 28);
        apply_stimulus(0, 1, 0, 0, 4'h0, 4'h0);
        goto_cycle(t + 29);
        apply_stimulus(0, 0, 0, 0, 4'h0, 4'h0);

        // Asynchronous reset in the middle of a step cycle clears everything
        goto_cycle(cyc + 3);
        apply_stimulus(1, 0, 0, 0, 4'h0, 4'h0);
        t = cyc + 1;
        expect_at(t,     "rst_run_start", 16'h0923, 1, 0, 0);
        expect_at(t + 3, "rst_run_mid",   16'h0923, 1, 0, 0);
        goto_cycle(t);
        apply_stimulus(0, 0, 0, 0, 4'h0, 4'h0);
        goto_cycle(t + 4);
        #1;
        rst = 1'b0;
        expect_at(t + 4, "async_reset", 16'h0000, 0, 1, 0);
        goto_cycle(t + 6);
        rst = 1'b1;
        expect_at(t + 7, "post_reset",   16'h0000, 0, 1, 0);
        expect_at(t + 8, "reload_edge",  16'h0000, 0, 1, 0);
        expect_at(t + 9, "reload_shown", 16'h5000, 0, 1, 0);
        goto_cycle(t + 7);
        apply_stimulus(0, 0, 0, 1, 4'h0, 4'h5);
        goto_cycle(t + 8);
        apply_stimulus(0, 0, 0, 0, 4'h0, 4'h0);

        goto_cycle(cyc + 3);
        n_checks++;
        if (exp_q.size() == 0 && step_q.size() == 0)
            n_pass++;
        else
            $display("[TB] FAIL drain: %0d window and %0d step expectations left, required 0",
                     exp_q.size(), step_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
